// File: rtl/riscv_opcodes_pkg.sv
// riscv_opcodes_pkg: major opcode field values (instr[6:2]) and load funct3 encodings.
package riscv_opcodes_pkg;
  localparam logic [6:2] OPC_LOAD     = 5'b00000;
  localparam logic [6:2] OPC_MISC_MEM = 5'b00011;
  localparam logic [6:2] OPC_OP_IMM   = 5'b00100;
  localparam logic [6:2] OPC_AUIPC    = 5'b00101;
  localparam logic [6:2] OPC_OP_IMM32 = 5'b00110;
  localparam logic [6:2] OPC_STORE    = 5'b01000;
  localparam logic [6:2] OPC_OP       = 5'b01100;
  localparam logic [6:2] OPC_LUI      = 5'b01101;
  localparam logic [6:2] OPC_OP32     = 5'b01110;
  localparam logic [6:2] OPC_BRANCH   = 5'b11000;
  localparam logic [6:2] OPC_JALR     = 5'b11001;
  localparam logic [6:2] OPC_JAL      = 5'b11011;
  localparam logic [6:2] OPC_SYSTEM   = 5'b11100;
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LD  = 3'b011;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] LWU = 3'b110;
endpackage

// File: rtl/riscv_state_pkg.sv
// riscv_state_pkg: pipeline instruction and trap bundles passed between stages.
package riscv_state_pkg;
  localparam int CAUSE_LD_ACCESS_FAULT = 5;
  typedef struct packed {
    logic [31:0] instr;
    logic        bubble;
    logic        dbg;
    logic        retired;
  } instruction_t;
  typedef struct packed {
    logic [11:0] interrupts;
    logic [15:0] exceptions;
    logic        any;
  } interrupts_exceptions_t;
endpackage

// File: rtl/riscv_wb_ldfmt.sv
// riscv_wb_ldfmt: aligns a raw data-memory word to the load address and sign/zero-extends it.
module riscv_wb_ldfmt
  import riscv_opcodes_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]           q,
  input  logic [$clog2(XLEN/8)-1:0] adr,
  input  logic [2:0]                funct3,
  output logic [XLEN-1:0]           d
);
  logic [XLEN-1:0] s;
  always_comb begin
    s = q >> {adr, 3'b000};
    case (funct3)
      LB:      d = XLEN'($signed(s[7:0]));
      LH:      d = XLEN'($signed(s[15:0]));
      LW:      d = XLEN'($signed(s[31:0]));
      LBU:     d = XLEN'(s[7:0]);
      LHU:     d = XLEN'(s[15:0]);
      LWU:     d = XLEN'(s[31:0]);
      default: d = s;
    endcase
  end
endmodule

// File: rtl/riscv_wb.sv
// riscv_wb: write-back stage; stalls on outstanding loads and formats load data for the register file.
// Optional RV12_WB_DMEM_ERR_EN turns dmem_err_i into a load-access-fault exception.
module riscv_wb
  import riscv_state_pkg::*;
  import riscv_opcodes_pkg::*;
#(
  parameter int              XLEN    = 32,
  parameter logic [XLEN-1:0] PC_INIT = 'h200
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  output logic                   wb_stall_o,
  input  logic [XLEN-1:0]        wb_pc_i,
  input  instruction_t           wb_insn_i,
  input  interrupts_exceptions_t wb_exceptions_i,
  input  logic [XLEN-1:0]        wb_r_i,
  input  logic [XLEN-1:0]        wb_memadr_i,
  input  logic [XLEN-1:0]        dmem_q_i,
  input  logic                   dmem_ack_i,
  input  logic                   dmem_err_i,
  output logic [XLEN-1:0]        wb_pc_o,
  output instruction_t           wb_insn_o,
  output interrupts_exceptions_t wb_exceptions_o,
  output logic [XLEN-1:0]        wb_r_o,
  output logic [4:0]             wb_dst_o,
  output logic                   wb_we_o
);
  localparam int AW = $clog2(XLEN/8);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t          state, state_nxt;
  logic [6:2]      opc;
  logic [4:0]      rd;
  logic            load, wr_rd, dmem_fault;
  logic [XLEN-1:0] ld_data;
  logic            unused_bits;
  assign opc   = wb_insn_i.instr[6:2];
  assign rd    = wb_insn_i.instr[11:7];
  assign load  = ~wb_insn_i.bubble & (opc == OPC_LOAD) & ~wb_exceptions_i.any;
  assign wr_rd = (opc inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_OP, OPC_OP_IMM,
                              OPC_OP32, OPC_OP_IMM32, OPC_LOAD})
               | ((opc == OPC_SYSTEM) & |wb_insn_i.instr[14:12]);
  assign wb_stall_o = load & ~dmem_ack_i;
`ifdef RV12_WB_DMEM_ERR_EN
  assign dmem_fault  = load & dmem_ack_i & dmem_err_i;
  assign unused_bits = ^{wb_insn_i.instr[31:15], wb_insn_i.instr[1:0], wb_memadr_i[XLEN-1:AW]};
`else
  assign dmem_fault  = 1'b0;
  assign unused_bits = ^{dmem_err_i, wb_insn_i.instr[31:15], wb_insn_i.instr[1:0], wb_memadr_i[XLEN-1:AW]};
`endif
  riscv_wb_ldfmt #(.XLEN(XLEN)) u_ldfmt (
    .q      (dmem_q_i),
    .adr    (wb_memadr_i[AW-1:0]),
    .funct3 (wb_insn_i.instr[14:12]),
    .d      (ld_data)
  );
  // A trap cancels the pending load, so WAIT must not outlive it.
  always_comb
    state_nxt = (state == IDLE) ? (wb_stall_o ? WAIT : IDLE)
                                : ((dmem_ack_i | wb_exceptions_i.any) ? IDLE : WAIT);
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state           <= IDLE;
      wb_pc_o         <= PC_INIT;
      wb_insn_o       <= '{instr: '0, bubble: 1'b1, dbg: 1'b0, retired: 1'b0};
      wb_exceptions_o <= '0;
      wb_r_o          <= '0;
      wb_dst_o        <= '0;
      wb_we_o         <= 1'b0;
    end else begin
      state <= state_nxt;
      if (wb_stall_o) begin
        wb_insn_o.bubble  <= 1'b1;
        wb_insn_o.retired <= 1'b0;
        wb_we_o           <= 1'b0;
      end else begin
        wb_pc_o         <= wb_pc_i;
        wb_insn_o       <= wb_insn_i;
        wb_exceptions_o <= wb_exceptions_i;
        wb_r_o          <= load ? ld_data : wb_r_i;
        wb_dst_o        <= rd;
        wb_we_o         <= ~wb_insn_i.bubble & ~wb_exceptions_i.any & wr_rd & |rd & ~dmem_fault;
        if (wb_exceptions_i.any) begin
          wb_insn_o.bubble  <= 1'b1;
          wb_insn_o.retired <= 1'b0;
        end
        if (dmem_fault) begin
          wb_exceptions_o.exceptions[CAUSE_LD_ACCESS_FAULT] <= 1'b1;
          wb_exceptions_o.any                               <= 1'b1;
          wb_insn_o.retired                                 <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_riscv_wb.sv
// tb_riscv_wb: vector table, hand-written stall/reset/trap sequences and a randomized run against a reference model.
module tb_riscv_wb;
  import riscv_state_pkg::*;
  localparam logic [6:0] LOAD = 7'b0000011, OP = 7'b0110011, OPI = 7'b0010011, STORE = 7'b0100011,
                         BRANCH = 7'b1100011, LUI = 7'b0110111, SYS = 7'b1110011;
  logic clk_i = 1'b0, rst_i = 1'b1;
  logic wb_stall_o, dmem_ack_i, dmem_err_i, wb_we_o;
  logic [31:0] wb_pc_i, wb_r_i, wb_memadr_i, dmem_q_i, wb_pc_o, wb_r_o;
  logic [4:0] wb_dst_o;
  instruction_t wb_insn_i, wb_insn_o;
  interrupts_exceptions_t wb_exceptions_i, wb_exceptions_o;
  int total = 0, bad = 0;

  riscv_wb #(.XLEN(32), .PC_INIT(32'h200)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .wb_stall_o(wb_stall_o), .wb_pc_i(wb_pc_i), .wb_insn_i(wb_insn_i),
    .wb_exceptions_i(wb_exceptions_i), .wb_r_i(wb_r_i), .wb_memadr_i(wb_memadr_i), .dmem_q_i(dmem_q_i),
    .dmem_ack_i(dmem_ack_i), .dmem_err_i(dmem_err_i), .wb_pc_o(wb_pc_o), .wb_insn_o(wb_insn_o),
    .wb_exceptions_o(wb_exceptions_o), .wb_r_o(wb_r_o), .wb_dst_o(wb_dst_o), .wb_we_o(wb_we_o));

  always #5 clk_i = ~clk_i;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", n, a, e);
    end
  endtask

  function automatic instruction_t mk(input logic [6:0] opc, input logic [4:0] rd, input logic [2:0] f3, input logic bub);
    instruction_t i;
    i.instr = {17'h0, f3, rd, opc};
    i.bubble = bub;
    i.dbg = 1'b0;
    i.retired = ~bub;
    return i;
  endfunction

  function automatic interrupts_exceptions_t exc(input logic any);
    interrupts_exceptions_t e;
    e = '0;
    e.any = any;
    e.exceptions[2] = any;
    return e;
  endfunction

  function automatic logic [31:0] ldval(input logic [2:0] f3, input logic [31:0] q, input logic [1:0] a);
    logic [31:0] w;
    w = q >> (8 * a);
    case (f3)
      3'd0: return {{24{w[7]}}, w[7:0]};
      3'd1: return {{16{w[15]}}, w[15:0]};
      3'd4: return {24'h0, w[7:0]};
      3'd5: return {16'h0, w[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic writes_rd(input logic [6:0] opc, input logic [2:0] f3);
    return opc inside {LUI, 7'b0010111, 7'b1101111, 7'b1100111, OP, OPI, LOAD} || (opc == SYS && f3 != 0);
  endfunction

  task automatic drive(input instruction_t i, input interrupts_exceptions_t e, input logic [31:0] pc,
                       input logic [31:0] r, input logic [31:0] adr, input logic [31:0] q,
                       input logic ack, input logic err);
    wb_insn_i = i; wb_exceptions_i = e; wb_pc_i = pc; wb_r_i = r;
    wb_memadr_i = adr; dmem_q_i = q; dmem_ack_i = ack; dmem_err_i = err;
    #1;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_reset(input string n);
    chk({n, "_pc"}, wb_pc_o, 32'h200);
    chk({n, "_bubble"}, wb_insn_o.bubble, 1);
    chk({n, "_dbg"}, wb_insn_o.dbg, 0);
    chk({n, "_retired"}, wb_insn_o.retired, 0);
    chk({n, "_exc"}, wb_exceptions_o, 0);
    chk({n, "_we"}, wb_we_o, 0);
    chk({n, "_r"}, wb_r_o, 0);
    chk({n, "_dst"}, wb_dst_o, 0);
  endtask

  typedef struct {
    string n;
    instruction_t insn;
    logic ex;
    logic [31:0] r, adr, q;
    logic ack;
    logic e_stall, e_we;
    logic [4:0] e_dst;
    logic [31:0] e_r;
  } vec_t;

  vec_t v[12];
  // reference model state
  logic [31:0] m_pc, m_r;
  logic [4:0] m_dst;
  logic m_we, m_bub, m_ret;
  interrupts_exceptions_t m_exc;

  initial begin
    v[0]  = '{"add",      mk(OP, 5, 0, 0),    0, 32'h1234, 0, 32'hFFFF_FFFF, 0, 0, 1, 5, 32'h1234};
    v[1]  = '{"lb",       mk(LOAD, 3, 0, 0),  0, 32'h9, 32'h1003, 32'h8000_0000, 1, 0, 1, 3, 32'hFFFF_FF80};
    v[2]  = '{"lw_rd0",   mk(LOAD, 0, 2, 0),  0, 0, 32'h1000, 32'hDEAD_BEEF, 1, 0, 0, 0, 32'hDEAD_BEEF};
    v[3]  = '{"bubble",   mk(OP, 5, 0, 1),    0, 32'h77, 0, 0, 0, 0, 0, 5, 32'h77};
    v[4]  = '{"add_exc",  mk(OP, 9, 0, 0),    1, 32'h55, 0, 0, 0, 0, 0, 9, 32'h55};
    v[5]  = '{"lbu",      mk(LOAD, 4, 4, 0),  0, 0, 32'h2001, 32'h0000_A500, 1, 0, 1, 4, 32'hA5};
    v[6]  = '{"lh",       mk(LOAD, 6, 1, 0),  0, 0, 32'h2002, 32'h8001_0000, 1, 0, 1, 6, 32'hFFFF_8001};
    v[7]  = '{"lhu",      mk(LOAD, 8, 5, 0),  0, 0, 32'h2000, 32'h1234_F00D, 1, 0, 1, 8, 32'hF00D};
    v[8]  = '{"store",    mk(STORE, 8, 2, 0), 0, 32'h3, 32'h40, 0, 0, 0, 0, 8, 32'h3};
    v[9]  = '{"opi_rd31", mk(OPI, 31, 0, 0),  0, 32'hCAFE, 0, 0, 0, 0, 1, 31, 32'hCAFE};
    v[10] = '{"spur_ack", mk(LOAD, 10, 2, 1), 0, 32'h0, 0, 32'h1111_2222, 1, 0, 0, 10, 32'h0};
    v[11] = '{"ld_exc",   mk(LOAD, 11, 2, 0), 1, 32'h66, 0, 0, 0, 0, 0, 11, 32'h66};

    drive(mk(OP, 0, 0, 1), exc(0), 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    chk_reset("reset");

    foreach (v[k]) begin
      drive(v[k].insn, exc(v[k].ex), 32'h100 + k, v[k].r, v[k].adr, v[k].q, v[k].ack, 0);
      chk({v[k].n, "_stall"}, wb_stall_o, v[k].e_stall);
      tick();
      chk({v[k].n, "_we"}, wb_we_o, v[k].e_we);
      chk({v[k].n, "_dst"}, wb_dst_o, v[k].e_dst);
      chk({v[k].n, "_r"}, wb_r_o, v[k].e_r);
      chk({v[k].n, "_pc"}, wb_pc_o, 32'h100 + k);
    end
    chk("exc_bubble", wb_insn_o.bubble, 1);

    // LHU with ack three cycles late
    drive(mk(LOAD, 7, 5, 0), exc(0), 32'h300, 0, 32'h2002, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      chk("wait_stall", wb_stall_o, 1);
      tick();
      chk("wait_bubble", wb_insn_o.bubble, 1);
      chk("wait_retired", wb_insn_o.retired, 0);
      chk("wait_we", wb_we_o, 0);
    end
    drive(mk(LOAD, 7, 5, 0), exc(0), 32'h300, 0, 32'h2002, 32'hBEEF_0000, 1, 0);
    chk("ack_stall", wb_stall_o, 0);
    tick();
    chk("lhu_late_r", wb_r_o, 32'h0000_BEEF);
    chk("lhu_late_we", wb_we_o, 1);
    chk("lhu_late_dst", wb_dst_o, 7);
    chk("lhu_late_retired", wb_insn_o.retired, 1);

    // trap while waiting releases the stall
    drive(mk(LOAD, 12, 2, 0), exc(0), 32'h400, 0, 0, 0, 0, 0);
    tick();
    drive(mk(LOAD, 12, 2, 0), exc(1), 32'h400, 0, 0, 0, 0, 0);
    chk("trap_stall", wb_stall_o, 0);
    tick();
    chk("trap_bubble", wb_insn_o.bubble, 1);
    chk("trap_we", wb_we_o, 0);
    chk("trap_any", wb_exceptions_o.any, 1);

    // reset during WAIT, then late ack
    drive(mk(LOAD, 13, 2, 0), exc(0), 32'h500, 0, 0, 0, 0, 0);
    tick();
    drive(mk(OP, 0, 0, 1), exc(0), 0, 0, 0, 0, 0, 0);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk_reset("rst_wait");
    drive(mk(OP, 13, 0, 1), exc(0), 32'h600, 0, 0, 32'hFFFF_FFFF, 1, 0);
    chk("late_ack_stall", wb_stall_o, 0);
    tick();
    chk("late_ack_we", wb_we_o, 0);
    chk("late_ack_r", wb_r_o, 0);

    // load with access error
    drive(mk(LOAD, 2, 2, 0), exc(0), 32'h700, 0, 0, 32'h55, 1, 1);
    tick();
`ifdef RV12_WB_DMEM_ERR_EN
    chk("err_we", wb_we_o, 0);
    chk("err_cause5", wb_exceptions_o.exceptions[5], 1);
    chk("err_any", wb_exceptions_o.any, 1);
    chk("err_retired", wb_insn_o.retired, 0);
`else
    chk("err_we", wb_we_o, 1);
    chk("err_r", wb_r_o, 32'h55);
    chk("err_any", wb_exceptions_o.any, 0);
`endif

    // randomized run against the reference model
    m_pc = wb_pc_o; m_r = wb_r_o; m_dst = wb_dst_o; m_we = wb_we_o;
    m_bub = wb_insn_o.bubble; m_ret = wb_insn_o.retired; m_exc = wb_exceptions_o;
    for (int c = 0; c < 400; c++) begin
      logic [6:0] opc;
      logic [2:0] f3;
      logic [4:0] rd;
      logic bub, ex, ack, err, is_ld, stall, fault;
      logic [31:0] pc, r, adr, q;
      case ($urandom_range(0, 6))
        0, 1, 2: opc = LOAD;
        3: opc = OP;
        4: opc = STORE;
        5: opc = SYS;
        default: opc = BRANCH;
      endcase
      f3 = 3'($urandom_range(0, 7));
      if (opc == LOAD) f3 = (f3 == 3 || f3 == 6 || f3 == 7) ? 3'd2 : f3;
      rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      bub = ($urandom_range(0, 7) == 0);
      ex = ($urandom_range(0, 7) == 0);
      ack = $urandom_range(0, 1) == 1;
      err = ($urandom_range(0, 3) == 0);
      pc = $urandom; r = $urandom; adr = $urandom; q = $urandom;
      drive(mk(opc, rd, f3, bub), exc(ex), pc, r, adr, q, ack, err);
      is_ld = !bub && opc == LOAD && !ex;
      stall = is_ld && !ack;
`ifdef RV12_WB_DMEM_ERR_EN
      fault = is_ld && ack && err;
`else
      fault = 1'b0;
`endif
      chk("rnd_stall", wb_stall_o, stall);
      if (stall) begin
        m_bub = 1; m_ret = 0; m_we = 0;
      end else begin
        m_pc = pc; m_dst = rd;
        m_r = is_ld ? ldval(f3, q, adr[1:0]) : r;
        m_we = !bub && !ex && writes_rd(opc, f3) && rd != 0 && !fault;
        m_bub = bub || ex;
        m_ret = !bub && !ex && !fault;
        m_exc = exc(ex);
        if (fault) begin
          m_exc.exceptions[5] = 1; m_exc.any = 1;
        end
      end
      tick();
      chk("rnd_pc", wb_pc_o, m_pc);
      chk("rnd_r", wb_r_o, m_r);
      chk("rnd_dst", wb_dst_o, m_dst);
      chk("rnd_we", wb_we_o, m_we);
      chk("rnd_bubble", wb_insn_o.bubble, m_bub);
      chk("rnd_retired", wb_insn_o.retired, m_ret);
      chk("rnd_exc", wb_exceptions_o, m_exc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/riscv_wb.md
RISCV_WB -- requirements
Module: riscv_wb

Interface
REQ-001 SHALL have parameter XLEN, default 32, data path width (32 or 64).
REQ-002 SHALL have parameter PC_INIT, default 'h200, reset value of wb_pc_o.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk_i  input  1  clock, all state on rising edge.
REQ-005 rst_i  input  1  synchronous active-high reset.
REQ-006 wb_stall_o  output  1  stall to upstream stage; high while a load awaits its data.
REQ-007 wb_pc_i  input  XLEN  PC from mem stage.
REQ-008 wb_insn_i  input  instruction_t  instruction (instr, bubble, dbg, retired) from mem stage.
REQ-009 wb_exceptions_i  input  interrupts_exceptions_t  exceptions from mem stage.
REQ-010 wb_r_i  input  XLEN  ALU/CSR result from mem stage.
REQ-011 wb_memadr_i  input  XLEN  load/store address from mem stage.
REQ-012 dmem_q_i  input  XLEN  raw aligned data-memory read word.
REQ-013 dmem_ack_i  input  1  dmem_q_i valid this cycle.
REQ-014 dmem_err_i  input  1  access error, qualified by dmem_ack_i (used only under RV12_WB_DMEM_ERR_EN).
REQ-015 wb_pc_o  output  XLEN  registered PC.
REQ-016 wb_insn_o  output  instruction_t  registered instruction.
REQ-017 wb_exceptions_o  output  interrupts_exceptions_t  registered exceptions.
REQ-018 wb_r_o  output  XLEN  register-file write data.
REQ-019 wb_dst_o  output  5  register-file destination (instr rd).
REQ-020 wb_we_o  output  1  register-file write enable.

Function
REQ-021 "Load" = ~wb_insn_i.bubble, opcode LOAD, ~wb_exceptions_i.any.
REQ-022 FSM states IDLE, WAIT; IDLE->WAIT on load & ~dmem_ack_i; WAIT->IDLE on dmem_ack_i; all other cases hold.
REQ-023 wb_stall_o = load & ~dmem_ack_i (combinational, state-independent); ack in same cycle as load gives zero stall.
REQ-024 Output registers (pc, insn, exceptions, r, dst, we) load only when wb_stall_o low; while stalled wb_insn_o.bubble=1, wb_insn_o.retired=0, wb_we_o=0.
REQ-025 Non-load: wb_r_o <= wb_r_i one cycle after input; wb_we_o <= 1 iff ~bubble, ~exceptions.any, opcode writes rd, rd!=0.
REQ-026 Load on ack: wb_r_o <= dmem_q_i shifted by memadr low bits (XLEN/8 byte lanes), then by funct3: 000 LB sign, 001 LH sign, 010 LW sign, 100 LBU, 101 LHU zero; 110 LWU, 011 LD only when XLEN=64; wb_we_o=1 iff rd!=0.
REQ-027 dmem_ack_i in IDLE with no load SHALL be ignored (no write, no state change).
REQ-028 wb_exceptions_i.any SHALL force bubble=1, retired=0, wb_we_o=0 on the next edge and send WAIT->IDLE without waiting for ack.
REQ-029 wb_exceptions_o SHALL register wb_exceptions_i unmodified (except REQ-034).

Reset
REQ-030 rst_i SHALL set state IDLE, wb_pc_o=PC_INIT, wb_insn_o.bubble=1, wb_insn_o.dbg=0, wb_insn_o.retired=0, wb_exceptions_o=0, wb_we_o=0, wb_r_o=0, wb_dst_o=0.
REQ-031 rst_i in WAIT SHALL abandon the load; a subsequent late ack SHALL be ignored per REQ-027.

Configuration
REQ-032 Macro RV12_WB_DMEM_ERR_EN SHALL compile in dmem error handling.
REQ-033 Without it dmem_err_i SHALL be ignored and loads always write data.
REQ-034 With it, dmem_ack_i & dmem_err_i on a load SHALL set wb_exceptions_o load-access-fault (cause 5), wb_we_o=0, retired=0.

Structure
REQ-035 Load funct3 codes and opcode constants SHALL come from riscv_opcodes_pkg; instruction_t and interrupts_exceptions_t from riscv_state_pkg; no new package types.
REQ-036 Load alignment/extension SHALL be sub-module riscv_wb_ldfmt (combinational, parameter XLEN).

Verification
REQ-037 ADD rd=5, wb_r_i=32'h1234 -> next cycle wb_we_o=1, wb_dst_o=5, wb_r_o=32'h1234, stall never high.
REQ-038 LB rd=3, memadr=..3, dmem_q_i=32'h80_00_00_00, ack same cycle -> wb_r_o=32'hFFFF_FF80, zero stall.
REQ-039 LHU rd=7, memadr=..2, ack after 3 cycles, dmem_q_i=32'hBEEF_0000 -> stall high 3 cycles, then wb_r_o=32'h0000_BEEF, we=1.
REQ-040 LW rd=0 with ack -> wb_we_o=0; spurious ack in IDLE -> no write.
REQ-041 Load in WAIT, rst_i pulsed -> all outputs at REQ-030 values, later ack ignored.
REQ-042 With RV12_WB_DMEM_ERR_EN: LW, ack+err -> cause-5 exception set, wb_we_o=0; without macro -> data written.
